uart_rx_sipo: RTL and testbench

UART receiver front end. It samples the serial line `data_rx` using the oversampled `baud_clk` from the BaudGen unit and rebuilds each frame: a start bit, 8 data bits sent LSB first, an optional parity bit, and a stop bit. It then presents the data byte in parallel, along with a one-cycle done pulse and error flags. It is the receiving counterpart of the Tx shift-register path and accepts every frame that path produces, including the extra idle bit on no-parity frames.

---
 rtl/uart_rx_sipo_pkg.sv | 31 +++
 rtl/uart_rx_sipo_if.sv | 38 +++
 rtl/uart_rx_sipo_sync.sv | 48 ++++
 rtl/uart_rx_sipo.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_sipo.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_sipo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: parity encodings, receiver state
//               encoding, data width and a parity-enable helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [1:0] PAR_NONE0 = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_NONE1 = 2'b11;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Both "none" encodings (00 and 11) mean the frame carries no parity bit.
  function automatic logic parity_enabled(input logic [1:0] ptype);
    return (ptype == PAR_ODD) || (ptype == PAR_EVEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sipo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sipo_if
// Description : Receiver-side bundle: serial line and parity selection in,
//               parallel byte and status flags out.
//   data_rx      serial line, idles high
//   parity_type  00/11 none, 01 odd, 10 even
//   data_out     last received byte
//   active_flag  frame in progress
//   done_flag    one-cycle frame-complete pulse
//   parity_error parity mismatch on last frame
//   stop_error   stop bit sampled low on last frame
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_sipo_if;
  import uart_pkg::*;

  logic                 data_rx;
  logic [1:0]           parity_type;
  logic [DATA_BITS-1:0] data_out;
  logic                 active_flag;
  logic                 done_flag;
  logic                 parity_error;
  logic                 stop_error;

  // master: the line driver / consumer of results
  modport master (
    output data_rx, parity_type,
    input  data_out, active_flag, done_flag, parity_error, stop_error
  );

  // slave: the receiver itself
  modport slave (
    input  data_rx, parity_type,
    output data_out, active_flag, done_flag, parity_error, stop_error
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sipo_sync.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for the serial line plus a delayed copy
//               for falling-edge detection. All flops reset to 1 (line idle)
//               so leaving reset never fakes a start edge.
//   baud_clk  receiver clock
//   reset_n   asynchronous active-low reset
//   data_rx   raw serial line
//   rx_s      synchronized line
//   fall      high for one cycle when rx_s goes 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  wire logic baud_clk,
  input  wire logic reset_n,
  input  wire logic data_rx,
  output logic      rx_s,
  output logic      fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic rx_p_q,  rx_p_d;

  always_comb begin
    sync1_d = data_rx;
    sync2_d = sync1_q;
    rx_p_d  = sync2_q;
  end

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rx_p_q  <= rx_p_d;
    end
  end

  assign rx_s = sync2_q;
  assign fall = rx_p_q & ~sync2_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sipo
// Description : Oversampling UART receiver. Rebuilds start / 8 data (LSB
//               first) / optional parity / stop frames and presents the byte
//               in parallel with a done pulse and error flags.
//   OVERSAMPLE  baud_clk cycles per bit (even, >= 4)
//   baud_clk    receiver clock
//   reset_n     asynchronous active-low reset
//   rx_if       slave side of uart_rx_sipo_if (line in, results out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input wire logic       baud_clk,
  input wire logic       reset_n,
  uart_rx_sipo_if.slave  rx_if
);

  localparam int                  TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0]   TICK_ONE  = TICK_W'(1);
  localparam logic [TICK_W-1:0]   TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam int                  BIT_W     = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_s;
  logic fall;

  uart_rx_sync u_sync (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .data_rx  (rx_if.data_rx),
    .rx_s     (rx_s),
    .fall     (fall)
  );

  rx_state_t            state_q,    state_d;
  logic [TICK_W-1:0]    tick_q,     tick_d;
  logic [BIT_W-1:0]     bit_q,      bit_d;
  logic [DATA_BITS-1:0] shreg_q,    shreg_d;
  logic                 par_q,      par_d;
  logic [1:0]           ptype_q,    ptype_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 active_q,   active_d;
  logic                 done_q,     done_d;
  logic                 perr_q,     perr_d;
  logic                 serr_q,     serr_d;

  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RX_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      ptype_q    <= PAR_NONE0;
      data_out_q <= '0;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
      serr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      ptype_q    <= ptype_d;
      data_out_q <= data_out_d;
      active_q   <= active_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
      serr_q     <= serr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    ptype_d    = ptype_q;
    data_out_d = data_out_q;
    active_d   = active_q;
    done_d     = 1'b0;
    perr_d     = perr_q;
    serr_d     = serr_q;

    unique case (state_q)
      RX_IDLE: begin
        tick_d = '0;
        if (fall) begin
          // The edge cycle itself counts as tick 0, so the start bit is
          // sampled OVERSAMPLE/2-1 cycles after the edge.
          tick_d   = TICK_ONE;
          ptype_d  = rx_if.parity_type;
          active_d = 1'b1;
          state_d  = RX_START;
        end
      end

      RX_START: begin
        if (tick_q == TICK_MID) begin
          if (rx_s) begin
            // Line went back high before mid-bit: glitch, drop silently.
            active_d = 1'b0;
            state_d  = RX_IDLE;
          end else begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = RX_DATA;
          end
        end
      end

      RX_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          // LSB arrives first, so shifting right leaves it in bit 0.
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = parity_enabled(ptype_q) ? RX_PARITY : RX_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

      RX_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          par_d   = rx_s;
          state_d = RX_STOP;
        end
      end

      RX_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d     = '0;
          data_out_d = shreg_q;
          serr_d     = ~rx_s;
          // XOR of data and parity is 1 for an odd count of ones; odd
          // parity expects 1, even parity expects 0.
          perr_d     = parity_enabled(ptype_q) &&
                       ((^shreg_q ^ par_q) != (ptype_q == PAR_ODD));
          done_d     = 1'b1;
          active_d   = 1'b0;
          state_d    = RX_IDLE;
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_if.data_out     = data_out_q;
  assign rx_if.active_flag  = active_q;
  assign rx_if.done_flag    = done_q;
  assign rx_if.parity_error = perr_q;
  assign rx_if.stop_error   = serr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sipo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sipo
// Description : Self-checking bench for uart_rx_sipo (OVERSAMPLE = 16).
//               Frames are driven bit by bit; each frame's expected byte,
//               flags and done cycle go into a queue, and a monitor pops and
//               compares on every done_flag pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sipo;

  localparam int OS = 16;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
    int         cyc;
  } exp_t;

  logic baud_clk;
  logic reset_n;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb[$];
  exp_t m_exp;
  logic prev_active;

  uart_rx_sipo_if rx_if ();

  uart_rx_sipo #(.OVERSAMPLE(OS)) dut (
    .baud_clk (baud_clk),
    .reset_n  (reset_n),
    .rx_if    (rx_if)
  );

  initial begin
    baud_clk = 1'b0;
    forever #5 baud_clk = ~baud_clk;
  end

  initial cyc = 0;
  always @(posedge baud_clk) cyc <= cyc + 1;

  // Scoreboard monitor: every done pulse must match the oldest queued frame.
  always @(negedge baud_clk) begin
    if (reset_n && rx_if.done_flag) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done at cyc=%0d data_out=%h", cyc, rx_if.data_out);
      end else begin
        m_exp = sb.pop_front();
        total++;
        if (rx_if.data_out !== m_exp.data) begin
          bad++;
          $display("FAIL data_out got=%h exp=%h", rx_if.data_out, m_exp.data);
        end
        total++;
        if (rx_if.parity_error !== m_exp.perr) begin
          bad++;
          $display("FAIL parity_error got=%b exp=%b (data %h)", rx_if.parity_error, m_exp.perr, m_exp.data);
        end
        total++;
        if (rx_if.stop_error !== m_exp.serr) begin
          bad++;
          $display("FAIL stop_error got=%b exp=%b (data %h)", rx_if.stop_error, m_exp.serr, m_exp.data);
        end
        total++;
        if (cyc !== m_exp.cyc) begin
          bad++;
          $display("FAIL done_timing got cyc=%0d exp cyc=%0d (data %h)", cyc, m_exp.cyc, m_exp.data);
        end
        total++;
        if (rx_if.active_flag !== 1'b0 || prev_active !== 1'b1) begin
          bad++;
          $display("FAIL active_at_done got now=%b prev=%b exp now=0 prev=1", rx_if.active_flag, prev_active);
        end
      end
    end
    prev_active = rx_if.active_flag;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    rx_if.data_rx = b;
    repeat (OS) @(negedge baud_clk);
  endtask

  // Caller must be at a negedge. Expected done cycle: edge seen by rx_s two
  // posedges after the drive (E), done visible at E+152 or E+168.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt,
                            input logic pbit, input logic sbit,
                            input logic idle_bit, input logic [1:0] pt_mid);
    exp_t e;
    logic pen;
    pen    = (pt == 2'b01) || (pt == 2'b10);
    e.data = d;
    e.serr = ~sbit;
    if (pt == 2'b01)      e.perr = ~(^{d, pbit});
    else if (pt == 2'b10) e.perr = ^{d, pbit};
    else                  e.perr = 1'b0;
    e.cyc = cyc + (pen ? 170 : 154);
    sb.push_back(e);
    rx_if.parity_type = pt;
    drive_bit(1'b0);
    rx_if.parity_type = pt_mid;
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(sbit);
    if (idle_bit) drive_bit(1'b1);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge baud_clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d exp=0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_values(input string name);
    total++;
    if (rx_if.data_out !== 8'h00) begin bad++; $display("FAIL %s_data_out got=%h exp=00", name, rx_if.data_out); end
    total++;
    if (rx_if.active_flag !== 1'b0) begin bad++; $display("FAIL %s_active got=%b exp=0", name, rx_if.active_flag); end
    total++;
    if (rx_if.done_flag !== 1'b0) begin bad++; $display("FAIL %s_done got=%b exp=0", name, rx_if.done_flag); end
    total++;
    if (rx_if.parity_error !== 1'b0) begin bad++; $display("FAIL %s_perr got=%b exp=0", name, rx_if.parity_error); end
    total++;
    if (rx_if.stop_error !== 1'b0) begin bad++; $display("FAIL %s_serr got=%b exp=0", name, rx_if.stop_error); end
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    rx_if.data_rx     = 1'b1;
    rx_if.parity_type = 2'b00;
    repeat (3) @(negedge baud_clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2 * OS) @(negedge baud_clk);
  endtask

  task automatic test_even_parity();
    send_frame(8'hA5, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10);
    wait_drain("even");
    repeat (OS) @(negedge baud_clk);
  endtask

  task automatic test_odd_parity();
    // Wrong parity bit; parity_type changed mid-frame must be ignored.
    send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b0, 2'b00);
    wait_drain("odd_bad");
    repeat (OS) @(negedge baud_clk);
    send_frame(8'h3C, 2'b01, 1'b1, 1'b1, 1'b0, 2'b10);
    wait_drain("odd_good");
    repeat (OS) @(negedge baud_clk);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h81, 2'b00, 1'b0, 1'b1, 1'b1, 2'b00);
    send_frame(8'h7E, 2'b11, 1'b0, 1'b1, 1'b1, 2'b11);
    wait_drain("b2b");
    repeat (OS) @(negedge baud_clk);
  endtask

  task automatic test_glitch();
    int c;
    c = cyc;
    rx_if.data_rx = 1'b0;
    repeat (4) @(negedge baud_clk);
    rx_if.data_rx = 1'b1;
    repeat (5) @(negedge baud_clk);
    total++;
    if (rx_if.active_flag !== 1'b1) begin
      bad++; $display("FAIL glitch_active_before got=%b exp=1 (cyc %0d)", rx_if.active_flag, cyc - c);
    end
    @(negedge baud_clk);
    total++;
    if (rx_if.active_flag !== 1'b0) begin
      bad++; $display("FAIL glitch_active_after got=%b exp=0 (cyc %0d)", rx_if.active_flag, cyc - c);
    end
    repeat (12 * OS) @(negedge baud_clk);
    total++;
    if (rx_if.data_out !== 8'h7E) begin
      bad++; $display("FAIL glitch_data_hold got=%h exp=7e", rx_if.data_out);
    end
  endtask

  task automatic test_stop_error();
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (40 * OS) @(negedge baud_clk);
    wait_drain("stop_err");
    total++;
    if (rx_if.active_flag !== 1'b0) begin
      bad++; $display("FAIL low_line_retrigger active got=%b exp=0", rx_if.active_flag);
    end
    rx_if.data_rx = 1'b1;
    repeat (2 * OS) @(negedge baud_clk);
    send_frame(8'h12, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10);
    wait_drain("recover");
    repeat (OS) @(negedge baud_clk);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hC3;
    rx_if.parity_type = 2'b10;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx_if.data_rx = d[4];
    repeat (OS / 2) @(negedge baud_clk);
    total++;
    if (rx_if.active_flag !== 1'b1) begin
      bad++; $display("FAIL midframe_active got=%b exp=1", rx_if.active_flag);
    end
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset_now");
    rx_if.data_rx = 1'b1;
    repeat (3) @(negedge baud_clk);
    check_reset_values("midreset_hold");
    reset_n = 1'b1;
    repeat (2 * OS) @(negedge baud_clk);
    send_frame(8'hF0, 2'b10, 1'b0, 1'b1, 1'b0, 2'b10);
    wait_drain("after_reset");
    repeat (OS) @(negedge baud_clk);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    prev_active = 1'b0;
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_back_to_back();
    test_glitch();
    test_stop_error();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
